// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-push interface between a memory-mapped write decoder and uart_tx.
//   wr_en   : byte-push strobe (master -> slave)
//   wr_data : byte to transmit, valid with wr_en (master -> slave)
//   full    : transmit FIFO full, push refused (slave -> master)
//   busy    : frame in progress or FIFO non-empty (slave -> master)
interface uart_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       busy;

    modport master (output wr_en, output wr_data, input full, input busy);
    modport slave  (input wr_en, input wr_data, output full, output busy);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, 8 data bits, 1 stop bit, LSB first.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN (8E1, 11 bit
// times per frame); default build is 8N1 (10 bit times per frame).
// Ports:
//   clk     : system clock, rising edge
//   n_reset : asynchronous active-low reset
//   bus     : uart_tx_if slave (wr_en, wr_data in; full, busy out)
//   txd     : serial line, idle high, registered
module uart_tx #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        n_reset,
    uart_tx_if.slave    bus,
    output logic        txd
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTF_W = $clog2(FIFO_DEPTH + 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTF_W-1:0]  count_q;

    logic full_c;
    logic push_c;
    logic pop_c;
    logic bit_done_c;

    assign full_c     = (count_q == CNTF_W'(FIFO_DEPTH));
    assign push_c     = bus.wr_en && !full_c;
    assign pop_c      = (state_q == ST_IDLE) && (count_q != '0);
    assign bit_done_c = (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    assign bus.full = full_c;
    assign bus.busy = (state_q != ST_IDLE) || (count_q != '0);
    assign txd      = txd_q;

    // FIFO storage, no reset needed: contents only read behind count
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    // FIFO pointers and occupancy; a refused push never touches them
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNTF_W'(1);
                2'b01:   count_q <= count_q - CNTF_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next state; txd_d reflects the current state so the line lags state by one cycle
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (pop_c) begin
                    state_d = ST_START;
                    shift_d = fifo_mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_mem[rd_ptr_q];
`endif
                end
            end
            ST_START: begin
                txd_d = 1'b0;
                if (bit_done_c) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                txd_d = shift_q[0];
                if (bit_done_c) begin
                    bit_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                txd_d = parity_q;
                if (bit_done_c) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end
            end
`endif
            ST_STOP: begin
                txd_d = 1'b1;
                if (bit_done_c) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

endmodule
